// File: rtl/ls_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : ls_down_counter
// Description : Synchronous 74LS-style binary down counter with parallel
//               load, cascade enables (CEP/CET), combinational borrow (TC)
//               and a registered zero-reached pulse (ZP).
//
//               Optional feature macro: LS_DOWN_COUNTER_AUTO_RELOAD_EN
//                 undefined : a count at Q==0 wraps to all-ones.
//                 defined   : a count at Q==0 reloads Q from the value
//                             captured at the last parallel load (RLD),
//                             giving a modulo-(RLD+1) divider.
//
// Ports       : CP   in   clock, rising edge
//               SR   in   synchronous reset, active-low
//               P    in   parallel load data [WIDTH-1:0]
//               PE   in   parallel load enable, active-low
//               CEP  in   count enable, parallel
//               CET  in   count enable, trickle (also gates TC)
//               Q    out  counter value, registered [WIDTH-1:0]
//               TC   out  terminal count / borrow, combinational
//               ZP   out  one-cycle pulse on a 1->0 count step, registered
//
// Revision    : 1.0 - initial release
// ============================================================================
module ls_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CP,
    input  logic             SR,
    input  logic [WIDTH-1:0] P,
    input  logic             PE,
    input  logic             CEP,
    input  logic             CET,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             ZP
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    // Declaration initializers give defined power-up values.
    logic [WIDTH-1:0] r_q   = '0;
    logic [WIDTH-1:0] r_rld = '0;
    logic             r_zp  = 1'b0;

    logic             w_ce;
    logic             w_q_zero;
    logic [WIDTH-1:0] w_wrap;

    assign w_ce     = CEP & CET & PE;
    assign w_q_zero = (r_q == '0);

`ifdef LS_DOWN_COUNTER_AUTO_RELOAD_EN
    // Modulo-N divider: the zero state is followed by the captured preload.
    assign w_wrap = r_rld;
`else
    // Plain binary wrap to all-ones. RLD is still maintained so both builds
    // share the same state; ORing with all-ones discards its value.
    assign w_wrap = r_rld | {WIDTH{1'b1}};
`endif

    always_ff @(posedge CP) begin
        if (!SR) begin
            r_q   <= '0;
            r_rld <= '0;
            r_zp  <= 1'b0;
        end else if (!PE) begin
            r_q   <= P;
            r_rld <= P;
            r_zp  <= 1'b0;
        end else if (w_ce) begin
            if (!w_q_zero) begin
                r_q  <= r_q - c_one;
                // Pulse only on the step that lands on zero.
                r_zp <= (r_q == c_one);
            end else begin
                r_q  <= w_wrap;
                r_zp <= 1'b0;
            end
        end else begin
            r_zp <= 1'b0;
        end
    end

    assign Q  = r_q;
    assign ZP = r_zp;
    // Unregistered so a cascaded stage sees the borrow in the same cycle.
    assign TC = CET & w_q_zero;

endmodule
`default_nettype wire

// File: doc/ls_down_counter.md
# ls_down_counter

Synchronous 74LS-style binary down counter with parallel load, cascade enables and a terminal-count (borrow) output. It counts toward zero instead of toward all-ones, so it serves as the decrementing companion to the team's up counter in timer and divider chains. It adds a registered zero-reached pulse and, when configured in, modulo-N auto-reload from a captured preload register. It sits between bus-side control logic and cascaded counter stages. TC ripples into the next stage's CET.

## Interface

Parameters:
- WIDTH, default 4, counter width in bits (≥2).

Ports (one clock; reset is synchronous and active-low):
- CP  input  1  clock; all state changes on rising edge.
- SR  input  1  synchronous reset, active-low; sampled on rising CP.
- P  input  WIDTH  parallel load data.
- PE  input  1  parallel load enable, active-low.
- CEP  input  1  count enable, parallel.
- CET  input  1  count enable, trickle; also gates TC.
- Q  output  WIDTH  counter value, registered.
- TC  output  1  terminal count (borrow), combinational: CET && (Q == 0).
- ZP  output  1  zero pulse, registered; one-cycle pulse when a count step moves Q from 1 to 0.

## Operation

- Internal state: Q, preload register RLD (WIDTH bits), ZP.
- Priority at each rising CP: SR low, then PE low, then count, then hold.
- SR low: Q←0, RLD←0, ZP←0. This overrides PE, CEP and CET.
- PE low (SR high): Q←P, RLD←P, ZP←0. This happens regardless of CEP and CET.
- Count condition CE = CEP && CET && PE (PE high).
- Count when Q≠0: Q←Q−1. ZP←1 only if Q==1, else ZP←0.
- Count when Q==0: Q←wrap value (see Configuration). ZP←0.
- Hold (CE low, no load, no reset): Q and RLD unchanged. ZP←0.
- Arithmetic is unsigned modulo 2^WIDTH. There are no X or overflow states.
- TC is purely combinational from CET and Q. There is no clock-to-TC register, so cascaded stages see a borrow in the same cycle.
- Every output has a defined power-up value via initializers: Q=0, RLD=0, ZP=0. TC equals CET at power-up.

## Timing

- Load latency: 1 cycle. Q shows P after the first rising CP that samples PE low.
- Count latency: 1 cycle per decrement.
- ZP rises in the same edge that makes Q go 1→0. It lasts exactly one cycle unless the next edge repeats a 1→0 step, which is impossible without an intervening load of 1.
- TC follows Q and CET in the same cycle. With CET high and Q==0, TC is high throughout that cycle.
- Reset mid-count: the next edge forces Q=0 and ZP=0. TC then equals CET.
- Load and count requested together: load wins and no decrement occurs.
- Reset and load requested together: reset wins, and RLD is cleared too.
- CEP high with CET low: Q holds, TC low, ZP low.
- Load of P=0 followed by counting: the first step goes through the Q==0 path. ZP stays low.

## Configuration

- Macro: LS_DOWN_COUNTER_AUTO_RELOAD_EN.
- Undefined: a count at Q==0 wraps Q to all-ones (2^WIDTH−1), as a plain 74LS down counter does. RLD is still written but does not affect Q.
- Defined: a count at Q==0 loads Q←RLD, giving a period of RLD+1 cycles per zero crossing (modulo-N divider).
  - If RLD==0, Q stays at 0 and ZP never pulses.

## Test plan

- Reset priority: SR=0, PE=0, P=4'hA, CEP=CET=1 for one edge -> Q=0, ZP=0, TC=1. Then SR=1, CET=0 -> TC=0.
- Load then count (WIDTH=4): PE=0, P=4'h3, one edge, then PE=1, CEP=CET=1 for 3 edges -> Q sequence 3,2,1,0. ZP high only in the cycle Q=0. TC high in that cycle.
- Wrap, macro undefined: continue counting from Q=0 -> Q=4'hF, ZP=0, TC=0.
- Auto-reload, macro defined: load P=4'h2, count 6 edges -> Q sequence 2,1,0,2,1,0,2. ZP pulses on each 1→0 step.
- Enable gating: Q=5, CEP=1, CET=0 for 4 edges -> Q stays 5, TC=0, ZP=0. CEP=0, CET=1 -> Q stays 5, TC=0.
- Mid-operation reset and load-over-count: at Q=2 assert PE=0 with P=4'h9 and CE=1 -> Q=9. Next edge SR=0 -> Q=0, RLD=0. With the macro defined, subsequent counts hold Q=0.
